n_cycle_multiplier: RTL and testbench
=====================================

# n_cycle_multiplier

Sequential unsigned multiply-add unit computing z = q·d + s. It is the inverse of the n-cycle divider: it takes an 8-bit quotient, an 8-bit divisor and an 8-bit remainder and rebuilds the 16-bit dividend. Its uses are divider result checking and the datapath's reconstruction step. It is a radix-2 shift-add engine that retires one multiplier bit per clock under a start/busy/done handshake.

## Interface

Parameters:
- WIDTH, 8, operand width; the result is 2·WIDTH bits.

Ports:
- clock  input  1  rising-edge clock; the block has one clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- q  input  WIDTH  multiplier operand (quotient).
- d  input  WIDTH  multiplicand operand (divisor).
- s  input  WIDTH  addend (remainder).
- busy  output  1  high while an operation is in flight (state ≠ IDLE).
- done  output  1  one-cycle registered pulse when z is updated.
- z  output  2·WIDTH  registered result; holds its value until the next completion.

## Operation

- All arithmetic is unsigned. q·d + s ≤ 0xFF00 for WIDTH=8, so there is no overflow and no carry-out port.
- Internal state:
  - acc: WIDTH+1 bits (carry plus upper half).
  - mq: WIDTH bits (multiplier / lower half).
  - dreg, sreg: WIDTH-bit operand registers.
  - cnt: $clog2(WIDTH) bits.
  - state.
- **IDLE**
  - When start=1: dreg←d, sreg←s, mq←q, acc←0, cnt←0, go to BUSY.
  - When start=0: hold.
- **BUSY** (one iteration per clock):
  - t = acc + (mq[0] ? dreg : 0).
  - {acc, mq} ← {1'b0, t, mq} >> 1, i.e. shift {t, mq} right by one.
  - cnt ← cnt+1.
  - When cnt = WIDTH−1, go to ADD.
- **ADD**
  - z ← {acc[WIDTH−1:0], mq} + sreg.
  - done ← 1.
  - Go to IDLE.
- done is 0 in every cycle except the one following the ADD edge.
- start while busy=1 is ignored. It is not queued and has no effect on the operation in progress.
- q, d and s are sampled only at the accepting edge. Later changes to them do not affect the result.
- Reset (any state, including mid-BUSY/ADD) takes effect at the next edge:
  - state=IDLE; acc, mq, dreg, sreg, cnt = 0.
  - z = 0, done = 0, busy = 0.
  - The aborted operation never produces done.
- Reset has priority over start in the same cycle.

## Timing

- Reset values: z=0, done=0, busy=0.
- Edge E0: start is accepted. busy reads 1 from the cycle after E0.
- Edges E1..E8: the 8 iterations (WIDTH in general).
- Edge E9: ADD. z and done update together; busy reads 0 from the cycle after E9.
- Latency is WIDTH+1 clocks from the accepting edge to done.
- start may be high in the same cycle as done. It is accepted at E10, so the minimum initiation interval is WIDTH+2 clocks.
- busy is decoded from the state register. It has no combinational path from start.

## Structure

- A shared package n_cycle_mult_pkg holds:
  - state enum {IDLE, BUSY, ADD};
  - MULT_WIDTH = 8;
  - MULT_CNT_W = $clog2(MULT_WIDTH).
- The divider uses the same width constants.
- One sub-module, shift_add_step. It is purely combinational and implements a single iteration: (acc, mq, dreg) → (acc_next, mq_next).
- The top level holds the FSM, the counter, the operand registers and the final add.

## Test plan

- **Reset:** hold reset 3 cycles with start=1 → z=0x0000, done=0, busy=0 throughout; no operation starts.
- **Basic case:** q=0x0D, d=0x0B, s=0x05, start for 1 cycle → busy for 9 cycles, done pulse exactly 9 clocks after the accepting edge, z=0x0094. This matches the divider's 0x0094/0x0B = 0x0D rem 0x05.
- **Corners:**
  - q=d=s=0xFF → z=0xFF00.
  - q=0x00, d=0x7F, s=0x2A → z=0x002A.
  - q=0x80, d=0x01, s=0 → z=0x0080.
- **Ignored inputs:** after accepting q=0x03, d=0x04, s=0, drive start=1 with q=d=0xFF for the whole BUSY period → single done, z=0x000C. A second operation begins only on the cycle after done.
- **Back-to-back:** start held constantly with operands changing each accept → done pulses every 10 clocks, each z matching the operands sampled at its own accepting edge.
- **Mid-operation reset:** assert reset during the 4th BUSY cycle → no done, z=0x0000, busy=0. Then run q=0x12, d=0x34, s=0x00 → z=0x03A8.

Source files
------------

// File: rtl/n_cycle_mult_pkg.sv
// Shared constants and state encoding for the n-cycle multiplier and its
// companion divider.
package n_cycle_mult_pkg;

   localparam int unsigned MULT_WIDTH = 8;
   localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ADD  = 2'd2
   } mult_state_e;

endpackage

// File: rtl/n_cycle_multiplier_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// upper half, then shift the {upper, lower} pair right by one bit.
module shift_add_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] mq,
   input  logic [WIDTH-1:0] dreg,
   output logic [WIDTH:0]   acc_next,
   output logic [WIDTH-1:0] mq_next
);

   logic [WIDTH:0] addend;
   logic [WIDTH:0] t;

   always_comb begin
      addend = mq[0] ? {1'b0, dreg} : '0;
      t      = acc + addend;
      // The bit shifted out of t becomes the new MSB of the lower half.
      acc_next = {1'b0, t[WIDTH:1]};
      mq_next  = {t[0], mq[WIDTH-1:1]};
   end

endmodule

// File: rtl/n_cycle_multiplier.sv
// Sequential unsigned multiply-add z = q*d + s, one multiplier bit per clock,
// under a start/busy/done handshake.
module n_cycle_multiplier
   import n_cycle_mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   q,
   input  logic [WIDTH-1:0]   d,
   input  logic [WIDTH-1:0]   s,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mult_state_e        state_q, state_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]   mq_q, mq_d;
   logic [WIDTH-1:0]   dreg_q, dreg_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     acc_step;
   logic [WIDTH-1:0]   mq_step;

   shift_add_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc      (acc_q),
      .mq       (mq_q),
      .dreg     (dreg_q),
      .acc_next (acc_step),
      .mq_next  (mq_step)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      dreg_d  = dreg_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               dreg_d  = d;
               sreg_d  = s;
               mq_d    = q;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d = acc_step;
            mq_d  = mq_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ADD;
            end
         end
         ADD: begin
            // The product never exceeds 2*WIDTH bits, so acc's carry bit is 0 here.
            z_d     = {acc_q[WIDTH-1:0], mq_q} + {{WIDTH{1'b0}}, sreg_q};
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mq_q    <= '0;
         dreg_q  <= '0;
         sreg_q  <= '0;
         cnt_q   <= '0;
         z_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         dreg_q  <= dreg_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign z    = z_q;

endmodule

// File: tb/tb_n_cycle_multiplier.sv
// Directed self-checking bench for n_cycle_multiplier with hand-computed results.
module tb_n_cycle_multiplier;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  q = '0;
   logic [7:0]  d = '0;
   logic [7:0]  s = '0;
   logic        busy;
   logic        done;
   logic [15:0] z;

   int vectors = 0;
   int miscompares = 0;

   n_cycle_multiplier #(
      .WIDTH (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .q     (q),
      .d     (d),
      .s     (s),
      .busy  (busy),
      .done  (done),
      .z     (z)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called one step after the accepting edge; stops on the sample showing done.
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cycles++;
         tick();
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] qi, input logic [7:0] di,
                         input logic [7:0] si, input logic [15:0] exp_z);
      int lat, bc;
      q = qi; d = di; s = si; start = 1'b1;
      tick();
      start = 1'b0;
      q = ~qi; d = ~di; s = ~si;
      wait_done(lat, bc);
      check({tag, "_latency"}, lat, 9);
      check({tag, "_busy_cycles"}, bc, 9);
      check({tag, "_z"}, {16'h0, z}, {16'h0, exp_z});
      check({tag, "_busy_at_done"}, {31'h0, busy}, 0);
      tick();
      check({tag, "_done_pulse"}, {31'h0, done}, 0);
      check({tag, "_z_hold"}, {16'h0, z}, {16'h0, exp_z});
   endtask

   initial begin
      int lat, bc, pulses;
      logic [7:0]  bq [3];
      logic [7:0]  bd [3];
      logic [7:0]  bs [3];
      logic [15:0] bz [3];

      // Reset held with start high: nothing may begin.
      reset = 1'b1; start = 1'b1; q = 8'h55; d = 8'h66; s = 8'h77;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_z", {16'h0, z}, 0);
         check("rst_done", {31'h0, done}, 0);
         check("rst_busy", {31'h0, busy}, 0);
      end
      reset = 1'b0; start = 1'b0;
      tick();
      check("post_rst_busy", {31'h0, busy}, 0);
      check("post_rst_done", {31'h0, done}, 0);

      run_op("basic", 8'h0D, 8'h0B, 8'h05, 16'h0094);
      run_op("all_ff", 8'hFF, 8'hFF, 8'hFF, 16'hFF00);
      run_op("q_zero", 8'h00, 8'h7F, 8'h2A, 16'h002A);
      run_op("q_msb", 8'h80, 8'h01, 8'h00, 16'h0080);

      // start and operand changes while busy must be ignored.
      q = 8'h03; d = 8'h04; s = 8'h00; start = 1'b1;
      tick();
      q = 8'hFF; d = 8'hFF;
      wait_done(lat, bc);
      check("ign_latency", lat, 9);
      check("ign_z", {16'h0, z}, 16'h000C);
      check("ign_busy_at_done", {31'h0, busy}, 0);
      tick();
      check("ign_second_accept", {31'h0, busy}, 1);
      check("ign_done_single", {31'h0, done}, 0);
      start = 1'b0;
      wait_done(lat, bc);
      check("ign_second_latency", lat, 9);
      check("ign_second_z", {16'h0, z}, 16'hFE01);
      tick();

      // Back-to-back with start held; each result uses its own accepted operands.
      bq[0] = 8'h12; bd[0] = 8'h10; bs[0] = 8'h01; bz[0] = 16'h0121;
      bq[1] = 8'hA5; bd[1] = 8'h3C; bs[1] = 8'h07; bz[1] = 16'h26B3;
      bq[2] = 8'h55; bd[2] = 8'hAA; bs[2] = 8'hFF; bz[2] = 16'h3971;
      q = bq[0]; d = bd[0]; s = bs[0]; start = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i < 2) begin
            q = bq[i+1]; d = bd[i+1]; s = bs[i+1];
         end else begin
            start = 1'b0;
            q = 8'hEE; d = 8'hDD; s = 8'hCC;
         end
         wait_done(lat, bc);
         check("b2b_latency", lat, 9);
         check("b2b_z", {16'h0, z}, {16'h0, bz[i]});
         if (i < 2) begin
            tick();
            check("b2b_reaccept", {31'h0, busy}, 1);
            check("b2b_done_pulse", {31'h0, done}, 0);
            if (i == 0) begin
               q = bq[2]; d = bd[2]; s = bs[2];
            end
         end
      end
      tick();
      check("b2b_idle", {31'h0, busy}, 0);

      // Reset during the 4th BUSY cycle aborts without a done pulse.
      q = 8'h20; d = 8'h20; s = 8'h10; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("mid_busy_before", {31'h0, busy}, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_z", {16'h0, z}, 0);
      check("mid_rst_busy", {31'h0, busy}, 0);
      check("mid_rst_done", {31'h0, done}, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      check("mid_rst_no_done", pulses, 0);
      run_op("after_rst", 8'h12, 8'h34, 8'h00, 16'h03A8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
